dcache_ctrl: RTL and testbench
==============================

// Module: dcache_ctrl
// PURPOSE
//  Direct-mapped, write-back, write-allocate data cache controller between the OTTER
//  load/store port and the cache line adapter. Holds tags, valid/dirty bits and 256-bit
//  lines in flops. Serves hits combinationally. On a miss it stalls the CPU, evicts a
//  dirty victim via cl_write, then fills the line via cl_read.
// PARAMETERS
//  NUM_SETS   16   lines in cache (power of 2); INDEX_W = log2(NUM_SETS)
//  LINE_WORDS 8    32-bit words per line (fixed: line = 256 bits, matches adapter)
// PORTS
//  CLK         in   1    clock, all state updates on posedge
//  RST         in   1    synchronous, active-high reset
//  cpu_addr    in   32   byte address; [4:2]=word, [4+INDEX_W:5]=index, rest=tag
//  cpu_wdata   in   32   store data
//  cpu_be      in   4    store byte enables
//  cpu_re      in   1    load request, held until cpu_stall low
//  cpu_we      in   1    store request, held until cpu_stall low
//  cpu_rdata   out  32   load data, valid when cpu_re & ~cpu_stall
//  cpu_stall   out  1    freeze CPU; request not yet complete
//  cl_addr     out  32   line base address to adapter ([4:0]=0)
//  cl_wdata    out  256  victim line to adapter (word i at [32i+31:32i])
//  cl_rdata    in   256  fill line from adapter, same word layout
//  cl_read     out  1    one-cycle fill request pulse
//  cl_write    out  1    one-cycle writeback request pulse
//  cl_busy     in   1    adapter transfer in progress
// BEHAVIOUR
//  Reset: all valid/dirty cleared, state IDLE; cpu_stall=0, cl_read=0, cl_write=0,
//   cl_addr=0, cpu_rdata=0 when no hit. Line data not reset.
//  hit = valid[idx] & tag[idx]==cpu_tag. Request = cpu_re|cpu_we (cpu_we wins if both).
//  States: IDLE, WB_REQ, WB_ARM, WB_WAIT, FILL_REQ, FILL_ARM, FILL_WAIT.
//  IDLE: no request -> stall 0. Hit -> stall 0; load: cpu_rdata = line word[4:2] same
//   cycle; store: bytes merged per cpu_be at posedge, dirty[idx]<=1. Miss -> stall 1;
//   victim valid&dirty -> WB_REQ else FILL_REQ.
//  WB_REQ: cl_write=1 one cycle; cl_addr={victim_tag,idx,5'b0}; cl_wdata=victim line,
//   held stable through WB_WAIT -> WB_ARM.
//  WB_ARM: one cycle (adapter raises cl_busy) -> WB_WAIT.
//  WB_WAIT: stay while cl_busy; on cl_busy=0 clear dirty[idx] -> FILL_REQ.
//  FILL_REQ: cl_read=1 one cycle; cl_addr={cpu_tag,idx,5'b0}, held through FILL_WAIT.
//   -> FILL_ARM -> FILL_WAIT.
//  FILL_WAIT: on cl_busy=0 latch cl_rdata into line, tag<=cpu_tag, valid<=1, dirty<=0
//   -> IDLE; access completes there as a hit next cycle.
//  cpu_stall=1 in every non-IDLE state and in IDLE on a miss.
//  Latency: hit 0 extra cycles; clean miss = 3 + adapter busy cycles + 1;
//   dirty miss adds 3 + adapter busy cycles.
//  cl_read and cl_write never both high; never re-pulsed while cl_busy high.
//  CPU address/data must be held while stalled; controller does not latch them.
//  Request dropped mid-miss: miss sequence still completes; no store merged.
//  RST mid-transfer: state to IDLE, all valid cleared immediately; in-flight
//   adapter transfer is discarded (adapter reset by same RST).
//  Store to line just filled: merge happens in IDLE hit cycle, never during fill.
// TESTING
//  Cold load 0x0000_0040, adapter returns words 0x1..0x8 -> one cl_read, addr 0x40,
//   no cl_write; cpu_rdata=0x1 when stall drops; repeat load: stall 0 same cycle.
//  Store 0xAABBCCDD be=4'b0010 to 0x44 after fill -> word1=0x0000CC02, dirty set,
//   no adapter traffic.
//  Load 0x0000_0240 (same index 2, new tag) after dirty store -> cl_write pulse with
//   cl_addr 0x40 and cl_wdata[63:32]=0x0000CC02, then cl_read at 0x240, in that order.
//  Conflict miss on clean line -> cl_read only, no cl_write.
//  RST asserted in FILL_WAIT -> next cycle stall 0, cl_* 0; prior-hit address misses.
//  cpu_re & cpu_we both high on hit -> treated as store, dirty set, rdata ignored.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller for the OTTER
// load/store port. Tags, valid/dirty bits and lines live in flops; misses go through the line adapter.
module dcache_ctrl #(
  parameter int NUM_SETS   = 16,
  parameter int LINE_WORDS = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [31:0]              cpu_addr,
  input  logic [31:0]              cpu_wdata,
  input  logic [3:0]               cpu_be,
  input  logic                     cpu_re,
  input  logic                     cpu_we,
  output logic [31:0]              cpu_rdata,
  output logic                     cpu_stall,
  output logic [31:0]              cl_addr,
  output logic [LINE_WORDS*32-1:0] cl_wdata,
  input  logic [LINE_WORDS*32-1:0] cl_rdata,
  output logic                     cl_read,
  output logic                     cl_write,
  input  logic                     cl_busy,
  output logic [2:0]               o_dbg_state
);

  localparam int INDEX_W = $clog2(NUM_SETS);
  localparam int TAG_W   = 27 - INDEX_W;
  localparam int LINE_W  = LINE_WORDS * 32;
  localparam int WORD_W  = $clog2(LINE_WORDS);
  localparam int OFF_W   = $clog2(LINE_W);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WB_REQ    = 3'd1,
    S_WB_ARM    = 3'd2,
    S_WB_WAIT   = 3'd3,
    S_FILL_REQ  = 3'd4,
    S_FILL_ARM  = 3'd5,
    S_FILL_WAIT = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [NUM_SETS-1:0]   r_valid;
  logic [NUM_SETS-1:0]   r_dirty;
  logic [TAG_W-1:0]      r_tag  [NUM_SETS];
  logic [LINE_W-1:0]     r_data [NUM_SETS];

  logic [WORD_W-1:0]     w_word;
  logic [OFF_W-1:0]      w_woff;
  logic [INDEX_W-1:0]    w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic [LINE_W-1:0]     w_line;
  logic [31:0]           w_rword;
  logic                  w_req;
  logic                  w_hit;
  logic                  w_store_hit;
  logic                  w_fill_done;
  logic                  w_wb_done;
  logic [1:0]            w_unused_addr;

  assign w_word        = cpu_addr[2 +: WORD_W];
  assign w_woff        = OFF_W'({w_word, 5'd0});
  assign w_idx         = cpu_addr[5 +: INDEX_W];
  assign w_tag         = cpu_addr[31 -: TAG_W];
  assign w_unused_addr = cpu_addr[1:0];
  assign w_line        = r_data[w_idx];
  assign w_rword       = w_line[w_woff +: 32];
  assign w_req         = cpu_re | cpu_we;
  assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  // cpu_we wins when both request lines are high, so a hit with cpu_we is always a store.
  assign w_store_hit   = !RST && (r_state == S_IDLE) && w_hit && cpu_we;
  assign w_fill_done   = !RST && (r_state == S_FILL_WAIT) && !cl_busy;
  assign w_wb_done     = (r_state == S_WB_WAIT) && !cl_busy;
  assign o_dbg_state   = r_state;

  always_comb begin
    w_next    = r_state;
    cpu_stall = 1'b1;
    cpu_rdata = '0;
    cl_read   = 1'b0;
    cl_write  = 1'b0;
    cl_addr   = '0;
    cl_wdata  = '0;
    case (r_state)
      S_IDLE: begin
        cpu_stall = w_req && !w_hit;
        if (w_hit) cpu_rdata = w_rword;
        if (w_req && !w_hit)
          w_next = (r_valid[w_idx] && r_dirty[w_idx]) ? S_WB_REQ : S_FILL_REQ;
      end
      S_WB_REQ, S_WB_ARM, S_WB_WAIT: begin
        cl_write = (r_state == S_WB_REQ);
        cl_addr  = {r_tag[w_idx], w_idx, 5'b0};
        cl_wdata = w_line;
        if (r_state == S_WB_REQ)      w_next = S_WB_ARM;
        else if (r_state == S_WB_ARM) w_next = S_WB_WAIT;
        else if (!cl_busy)            w_next = S_FILL_REQ;
      end
      S_FILL_REQ, S_FILL_ARM, S_FILL_WAIT: begin
        cl_read = (r_state == S_FILL_REQ);
        cl_addr = {w_tag, w_idx, 5'b0};
        if (r_state == S_FILL_REQ)      w_next = S_FILL_ARM;
        else if (r_state == S_FILL_ARM) w_next = S_FILL_WAIT;
        else if (!cl_busy)              w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      r_state <= w_next;
      if (w_store_hit) r_dirty[w_idx] <= 1'b1;
      if (w_wb_done)   r_dirty[w_idx] <= 1'b0;
      if (w_fill_done) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end
    end
  end

  // Tag and line storage carry no reset; the valid bits alone decide whether they mean anything.
  always_ff @(posedge CLK) begin
    if (w_fill_done) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= cl_rdata;
    end else if (w_store_hit) begin
      for (int b = 0; b < 4; b++)
        if (cpu_be[b]) r_data[w_idx][w_woff + OFF_W'(8 * b) +: 8] <= cpu_wdata[8 * b +: 8];
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a busy-counter adapter model, an expected queue of
// adapter requests, and hand-computed load/latency values.
module tb_dcache_ctrl;

  localparam int BUSY_N = 2;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [31:0]  cpu_addr = '0;
  logic [31:0]  cpu_wdata = '0;
  logic [3:0]   cpu_be = '0;
  logic         cpu_re = 1'b0;
  logic         cpu_we = 1'b0;
  logic [31:0]  cpu_rdata;
  logic         cpu_stall;
  logic [31:0]  cl_addr;
  logic [255:0] cl_wdata;
  logic [255:0] cl_rdata = '0;
  logic         cl_read;
  logic         cl_write;
  logic         cl_busy;
  logic [2:0]   o_dbg_state;

  int           n_chk = 0;
  int           n_err = 0;
  int           busy_cnt = 0;
  logic [31:0]  exp_q[$];
  logic [255:0] wb_line = '0;
  logic [31:0]  rd;
  int           stalls;

  dcache_ctrl dut (
    .CLK(CLK), .RST(RST),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .cl_addr(cl_addr), .cl_wdata(cl_wdata), .cl_rdata(cl_rdata),
    .cl_read(cl_read), .cl_write(cl_write), .cl_busy(cl_busy),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Adapter model: busy for BUSY_N cycles after each request pulse.
  always @(posedge CLK) begin
    if (RST)                       busy_cnt <= 0;
    else if (cl_read || cl_write)  busy_cnt <= BUSY_N;
    else if (busy_cnt > 0)         busy_cnt <= busy_cnt - 1;
  end
  assign cl_busy = (busy_cnt != 0);

  // Scoreboard: every request pulse must match the head of exp_q (writes tagged with bit 0).
  always @(negedge CLK) begin
    if (!RST && (cl_read || cl_write)) begin
      chk("rw_excl", {31'b0, cl_read & cl_write}, 32'h0);
      if (cl_write) wb_line = cl_wdata;
      if (exp_q.size() == 0) chk("unexp_req", cl_addr | {31'b0, cl_write}, 32'hFFFF_FFFF);
      else                   chk("req_addr", cl_addr | {31'b0, cl_write}, exp_q.pop_front());
    end
  end

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32 * i +: 32] = base + 32'(i + 1);
    return l;
  endfunction

  // driver: hold a request until stall drops, sample rdata, release after the commit edge
  task automatic access(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                        input logic re, input logic we,
                        output logic [31:0] rdata, output int n_stall);
    @(negedge CLK);
    cpu_addr = addr; cpu_wdata = wdata; cpu_be = be; cpu_re = re; cpu_we = we;
    n_stall = 0;
    #1;
    while (cpu_stall && n_stall < 100) begin
      @(negedge CLK); #1;
      n_stall++;
    end
    if (n_stall >= 100) chk("timeout", 32'd1, 32'd0);
    rdata = cpu_rdata;
    @(posedge CLK); #1;
    cpu_re = 1'b0; cpu_we = 1'b0;
  endtask

  initial begin
    int k;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK); #1;
    chk("rst_stall", {31'b0, cpu_stall}, 32'h0);
    chk("rst_cl_read", {31'b0, cl_read}, 32'h0);
    chk("rst_cl_write", {31'b0, cl_write}, 32'h0);
    chk("rst_cl_addr", cl_addr, 32'h0);
    chk("rst_rdata", cpu_rdata, 32'h0);

    // cold load: single fill at 0x40, word0 = 1
    cl_rdata = mk_line(32'h0);
    exp_q.push_back(32'h40);
    access(32'h40, 32'h0, 4'h0, 1'b1, 1'b0, rd, stalls);
    chk("cold_rdata", rd, 32'h1);
    chk("cold_stalls", 32'(stalls), 32'd5);
    access(32'h40, 32'h0, 4'h0, 1'b1, 1'b0, rd, stalls);
    chk("hit_stalls", 32'(stalls), 32'd0);
    chk("hit_rdata", rd, 32'h1);
    access(32'h4C, 32'h0, 4'h0, 1'b1, 1'b0, rd, stalls);
    chk("hit_word3", rd, 32'h4);

    // byte-lane store on hit
    access(32'h44, 32'hAABBCCDD, 4'b0010, 1'b0, 1'b1, rd, stalls);
    chk("store_stalls", 32'(stalls), 32'd0);
    access(32'h44, 32'h0, 4'h0, 1'b1, 1'b0, rd, stalls);
    chk("store_merge", rd, 32'h0000CC02);

    // dirty conflict: writeback of 0x40 then fill of 0x240
    cl_rdata = mk_line(32'h10);
    exp_q.push_back(32'h41);
    exp_q.push_back(32'h240);
    access(32'h240, 32'h0, 4'h0, 1'b1, 1'b0, rd, stalls);
    chk("wb_word1", wb_line[63:32], 32'h0000CC02);
    chk("wb_word0", wb_line[31:0], 32'h1);
    chk("dirty_rdata", rd, 32'h11);
    chk("dirty_stalls", 32'(stalls), 32'd9);

    // clean conflict: fill only
    cl_rdata = mk_line(32'h20);
    exp_q.push_back(32'h440);
    access(32'h440, 32'h0, 4'h0, 1'b1, 1'b0, rd, stalls);
    chk("clean_rdata", rd, 32'h21);
    chk("clean_stalls", 32'(stalls), 32'd5);

    // re & we together on a hit behave as a store
    access(32'h448, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1, rd, stalls);
    chk("rw_stalls", 32'(stalls), 32'd0);
    access(32'h448, 32'h0, 4'h0, 1'b1, 1'b0, rd, stalls);
    chk("rw_merge", rd, 32'hDEADBEEF);
    cl_rdata = mk_line(32'h30);
    exp_q.push_back(32'h441);
    exp_q.push_back(32'h40);
    access(32'h40, 32'h0, 4'h0, 1'b1, 1'b0, rd, stalls);
    chk("rw_wb_word2", wb_line[95:64], 32'hDEADBEEF);
    chk("refill_rdata", rd, 32'h31);

    // reset while a fill is in flight
    cl_rdata = mk_line(32'h40);
    exp_q.push_back(32'h60);
    @(negedge CLK);
    cpu_addr = 32'h60; cpu_be = 4'h0; cpu_re = 1'b1; cpu_we = 1'b0;
    k = 0;
    while (o_dbg_state != 3'd6 && k < 20) begin
      @(negedge CLK);
      k++;
    end
    chk("reach_fill_wait", {29'b0, o_dbg_state}, 32'd6);
    RST = 1'b1; cpu_re = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rst_mid_stall", {31'b0, cpu_stall}, 32'h0);
    chk("rst_mid_read", {31'b0, cl_read}, 32'h0);
    chk("rst_mid_write", {31'b0, cl_write}, 32'h0);
    chk("rst_mid_addr", cl_addr, 32'h0);
    cl_rdata = mk_line(32'h50);
    exp_q.push_back(32'h40);
    access(32'h40, 32'h0, 4'h0, 1'b1, 1'b0, rd, stalls);
    chk("post_rst_stalls", 32'(stalls), 32'd5);
    chk("post_rst_rdata", rd, 32'h51);

    repeat (3) @(negedge CLK);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
